// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, control FSM states and datapath select encodings.
// The imm_type encoding here is also the one the immediate generator decodes.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_IMM   = 2'b01,
    PC_ALU   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_CMP   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  // Exactly one bit is set for any opcode.
  typedef struct packed {
    logic r;
    logic i_arith;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic system;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier: maps instr[6:0] onto a one-hot instruction class.
module ctrl_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output op_class_t  cls_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OPC_OP:     cls_o.r       = 1'b1;
      OPC_OP_IMM: cls_o.i_arith = 1'b1;
      OPC_LOAD:   cls_o.load    = 1'b1;
      OPC_STORE:  cls_o.store   = 1'b1;
      OPC_BRANCH: cls_o.branch  = 1'b1;
      OPC_JAL:    cls_o.jal     = 1'b1;
      OPC_JALR:   cls_o.jalr    = 1'b1;
      OPC_LUI:    cls_o.lui     = 1'b1;
      OPC_AUIPC:  cls_o.auipc   = 1'b1;
      OPC_SYSTEM: cls_o.system  = 1'b1;
      default:    cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/exec/mem/writeback over a shared
// datapath, handshakes with unified memory and counts retired instructions.
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_src_a,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_type,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] instret_q;
  op_class_t        cls;
  imm_type_e        imm_c;

  // Only the opcode field steers control; the rest of the IR feeds the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[31:7];

  ctrl_decode u_decode (
    .opcode_i (instr[6:0]),
    .cls_o    (cls)
  );

  always_comb begin
    imm_c = IMM_I;
    if (cls.store)                  imm_c = IMM_S;
    else if (cls.branch)            imm_c = IMM_B;
    else if (cls.lui || cls.auipc)  imm_c = IMM_U;
    else if (cls.jal)               imm_c = IMM_J;
  end

  // Outputs are held at zero for as long as rst is high, so an access in flight is dropped.
  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    alu_src_a = SRC_A_RS1;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    imm_type  = IMM_I;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            state_d  = DECODE;
          end
        end
        DECODE: begin
          imm_type = imm_c;
          if (cls.system) begin
            halted_d = 1'b1;
            state_d  = TRAP;
          end else if (cls.illegal) begin
            illegal_d = 1'b1;
            state_d   = TRAP;
          end else begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          imm_type = imm_c;
          state_d  = WB;
          if (cls.r) begin
            alu_op = ALU_FUNCT;
          end else if (cls.i_arith) begin
            alu_src_b = 1'b1;
            alu_op    = ALU_FUNCT;
          end else if (cls.load || cls.store) begin
            alu_src_b = 1'b1;
            state_d   = MEM;
          end else if (cls.lui) begin
            alu_src_a = SRC_A_ZERO;
            alu_src_b = 1'b1;
          end else if (cls.auipc || cls.jal) begin
            alu_src_a = SRC_A_PC;
            alu_src_b = 1'b1;
          end else if (cls.jalr) begin
            alu_src_b = 1'b1;
          end else if (cls.branch) begin
            alu_op   = ALU_CMP;
            pc_write = 1'b1;
            pc_src   = branch_taken ? PC_IMM : PC_PLUS4;
            state_d  = FETCH;
          end
        end
        MEM: begin
          imm_type = imm_c;
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = cls.store;
          if (mem_ready) begin
            if (cls.store) begin
              pc_write = 1'b1;
              state_d  = FETCH;
            end else begin
              state_d = WB;
            end
          end
        end
        WB: begin
          imm_type  = imm_c;
          reg_write = 1'b1;
          pc_write  = 1'b1;
          state_d   = FETCH;
          if (cls.load)                 wb_sel = WB_MEM;
          else if (cls.jal || cls.jalr) wb_sel = WB_PC4;
          if (cls.jal)       pc_src = PC_IMM;
          else if (cls.jalr) pc_src = PC_ALU;
        end
        TRAP: ;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      if (pc_write) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction schedule model feeding a per-cycle scoreboard,
// plus literal pins on retire count and trap flags.
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      instr = 32'h0;
  logic             mem_ready = 1'b0;
  logic             branch_taken = 1'b0;
  logic             ir_write, pc_write, mem_req, mem_we, addr_sel, reg_write;
  logic             alu_src_b, halted, illegal;
  logic [1:0]       pc_src, wb_sel, alu_src_a, alu_op;
  logic [2:0]       imm_type, state;
  logic [CNT_W-1:0] instret;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .addr_sel     (addr_sel),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .imm_type     (imm_type),
    .halted       (halted),
    .illegal      (illegal),
    .instret      (instret),
    .state        (state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- model types and state ----------------
  typedef struct packed {
    logic [2:0] st;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [1:0] a;
    logic       b;
    logic [1:0] op;
    logic [2:0] imm;
    logic       halted;
    logic       illegal;
  } ctl_t;
  localparam int CTL_W = $bits(ctl_t);

  typedef enum int {C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_SYS, C_ILL} cls_e;

  logic [CTL_W-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_cnt_q[$];
  int               n_tests = 0;
  int               n_fail = 0;
  bit               m_halted = 1'b0;
  bit               m_illegal = 1'b0;
  int               m_instret = 0;
  logic [31:0]      ir = 32'h0;

  function automatic cls_e classify(input logic [6:0] op);
    case (op)
      7'h33:   return C_R;
      7'h13:   return C_I;
      7'h03:   return C_LD;
      7'h23:   return C_ST;
      7'h63:   return C_BR;
      7'h6F:   return C_JAL;
      7'h67:   return C_JALR;
      7'h37:   return C_LUI;
      7'h17:   return C_AUIPC;
      7'h73:   return C_SYS;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input cls_e k);
    case (k)
      C_ST:            return 3'd1;
      C_BR:            return 3'd2;
      C_LUI, C_AUIPC:  return 3'd3;
      C_JAL:           return 3'd4;
      default:         return 3'd0;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    ctl_t             act;
    logic [CTL_W-1:0] e;
    logic [CNT_W-1:0] ec;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ec = exp_cnt_q.pop_front();
      act = {state, ir_write, pc_write, pc_src, mem_req, mem_we, addr_sel, reg_write,
             wb_sel, alu_src_a, alu_src_b, alu_op, imm_type, halted, illegal};
      check("ctl", 32'(act), 32'(e));
      check("instret", 32'(instret), 32'(ec));
    end
  end

  // ---------------- driver tasks ----------------
  // One clock cycle: drive inputs just after the edge and queue what that cycle must show.
  task automatic step(input logic r, input logic rdy, input logic tk, input ctl_t c);
    @(posedge clk);
    #1;
    rst          = r;
    mem_ready    = rdy;
    branch_taken = tk;
    instr        = ir;
    c.halted     = m_halted;
    c.illegal    = m_illegal;
    exp_q.push_back(c);
    exp_cnt_q.push_back(CNT_W'(m_instret));
    if (c.pc_write) m_instret++;
  endtask

  task automatic do_reset(input int n);
    ctl_t c;
    m_instret = 0;
    m_halted  = 1'b0;
    m_illegal = 1'b0;
    for (int i = 0; i < n; i++) begin
      c = '0;
      step(1'b1, rb(), rb(), c);
    end
  endtask

  task automatic fetch_stall(input int n);
    ctl_t c;
    for (int i = 0; i < n; i++) begin
      c = '0;
      c.mem_req = 1'b1;
      step(1'b0, 1'b0, rb(), c);
    end
  endtask

  task automatic trap_cycles(input int n);
    ctl_t c;
    for (int i = 0; i < n; i++) begin
      c = '0;
      c.st = 3'd5;
      step(1'b0, rb(), rb(), c);
    end
  endtask

  // Whole-instruction schedule: phase list per class, memory phases stretched by waits.
  task automatic run_instr(input logic [31:0] ins, input int fwait, input int mwait, input logic tk);
    cls_e       k;
    logic [2:0] imm;
    ctl_t       c;
    k   = classify(ins[6:0]);
    imm = imm_of(k);
    fetch_stall(fwait);
    c = '0;
    c.mem_req  = 1'b1;
    c.ir_write = 1'b1;
    step(1'b0, 1'b1, rb(), c);
    ir = ins;
    c = '0;
    c.st  = 3'd1;
    c.imm = imm;
    step(1'b0, rb(), rb(), c);
    if (k == C_SYS) m_halted = 1'b1;
    if (k == C_ILL) m_illegal = 1'b1;
    if (k == C_SYS || k == C_ILL) return;
    c = '0;
    c.st  = 3'd2;
    c.imm = imm;
    case (k)
      C_R:           c.op = 2'b10;
      C_I:           begin c.b = 1'b1; c.op = 2'b10; end
      C_LD, C_ST:    c.b = 1'b1;
      C_LUI:         begin c.a = 2'b10; c.b = 1'b1; end
      C_AUIPC, C_JAL: begin c.a = 2'b01; c.b = 1'b1; end
      C_JALR:        c.b = 1'b1;
      C_BR:          begin c.op = 2'b01; c.pc_write = 1'b1; c.pc_src = tk ? 2'b01 : 2'b00; end
      default:       ;
    endcase
    step(1'b0, rb(), (k == C_BR) ? tk : rb(), c);
    if (k == C_BR) return;
    if (k == C_LD || k == C_ST) begin
      c = '0;
      c.st       = 3'd3;
      c.imm      = imm;
      c.mem_req  = 1'b1;
      c.addr_sel = 1'b1;
      c.mem_we   = (k == C_ST);
      for (int i = 0; i < mwait; i++) step(1'b0, 1'b0, rb(), c);
      c.pc_write = (k == C_ST);
      step(1'b0, 1'b1, rb(), c);
      if (k == C_ST) return;
    end
    c = '0;
    c.st        = 3'd4;
    c.imm       = imm;
    c.reg_write = 1'b1;
    c.pc_write  = 1'b1;
    c.wb_sel    = (k == C_LD) ? 2'b01 : (k == C_JAL || k == C_JALR) ? 2'b10 : 2'b00;
    c.pc_src    = (k == C_JAL) ? 2'b01 : (k == C_JALR) ? 2'b10 : 2'b00;
    step(1'b0, rb(), rb(), c);
  endtask

  // Stall one FETCH cycle and pin the retire count with a hand-computed literal.
  task automatic pin_fetch(input string nm, input int exp_cnt);
    fetch_stall(1);
    @(negedge clk);
    check({nm, "_state"}, 32'(state), 32'd0);
    check({nm, "_instret"}, 32'(instret), exp_cnt);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    do_reset(2);
    fetch_stall(2);
    do_reset(2);
    pin_fetch("reset_abort", 0);

    run_instr(32'h00208033, 0, 0, 1'b0);   // add
    pin_fetch("add", 1);
    run_instr(32'h0000A103, 0, 2, 1'b0);   // lw, two memory wait cycles
    pin_fetch("lw", 2);
    run_instr(32'h00208463, 0, 0, 1'b1);   // beq taken
    run_instr(32'h00208463, 0, 0, 1'b0);   // beq not taken
    pin_fetch("beq", 4);
    run_instr(32'h000080E7, 0, 0, 1'b0);   // jalr
    run_instr(32'h0020A023, 1, 1, 1'b0);   // sw
    run_instr(32'h008000EF, 0, 0, 1'b0);   // jal
    run_instr(32'h123450B7, 0, 0, 1'b0);   // lui
    run_instr(32'h00001097, 2, 0, 1'b0);   // auipc
    run_instr(32'h00108093, 1, 0, 1'b0);   // addi
    pin_fetch("mix", 10);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) run_instr(32'h00108093, 0, 0, 1'b0);
      else            run_instr(32'h00208463, 0, 0, (i % 4) == 1);
    end
    pin_fetch("wrap", 2);                  // 18 retires modulo 16

    run_instr(32'h0000007F, 0, 0, 1'b0);   // unknown opcode
    trap_cycles(10);
    @(negedge clk);
    check("ill_state", 32'(state), 32'd5);
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_halted", 32'(halted), 32'd0);
    check("ill_instret", 32'(instret), 32'd2);

    do_reset(1);
    run_instr(32'h00000073, 0, 0, 1'b0);   // ecall
    trap_cycles(10);
    @(negedge clk);
    check("ecall_state", 32'(state), 32'd5);
    check("ecall_halted", 32'(halted), 32'd1);
    check("ecall_illegal", 32'(illegal), 32'd0);
    check("ecall_instret", 32'(instret), 32'd0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control FSM for the RV32I core. It sequences the fetch, decode, execute, memory and writeback phases over a shared datapath: one ALU, one memory port, the immediate generator and the register file.
- Drives every datapath enable and mux select from the latched instruction opcode.
- Handshakes with the unified memory.
- Counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
instr  in  32  instruction register contents; only [6:0] decoded here
mem_ready  in  1  memory completes the current access when high at a clk edge
branch_taken  in  1  comparator result, valid in EXEC
ir_write  out  1  load instr register from memory read data
pc_write  out  1  update PC from pc_src
pc_src  out  2  00 PC+4, 01 PC+imm, 10 ALU result with bit0 cleared
mem_req  out  1  memory access request
mem_we  out  1  store when high, qualified by mem_req
addr_sel  out  1  memory address: 0 PC, 1 ALU result
reg_write  out  1  register file write enable
wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4
alu_src_a  out  2  00 rs1, 01 PC, 10 zero
alu_src_b  out  1  0 rs2, 1 immediate
alu_op  out  2  00 add, 01 compare/sub, 10 funct-decoded
imm_type  out  3  0 I, 1 S, 2 B, 3 U, 4 J
halted  out  1  sticky; SYSTEM opcode reached
illegal  out  1  sticky; unknown opcode decoded
instret  out  CNT_W  retired-instruction count
state  out  3  current state, for debug

Behaviour:
- Reset (rst high, asynchronous):
  - state forced to FETCH; instret, halted, illegal cleared.
  - All control outputs forced to 0 combinationally while rst is high, including mem_req.
  - Reset mid-access abandons the access; no ir_write or pc_write occurs.
- Outputs are Moore: a function of state and latched opcode only. branch_taken and mem_ready affect only the write enables in the cycle they are sampled.
- FETCH:
  - mem_req=1, addr_sel=0, mem_we=0.
  - Hold until mem_ready=1, then ir_write=1 in that same cycle and go to DECODE.
  - mem_req stays high continuously while waiting.
  - mem_ready is ignored in any state where mem_req=0.
- DECODE: classify opcode.
  - 1110011 (SYSTEM) -> TRAP, sets halted.
  - Any opcode outside the ten RV32I classes -> TRAP, sets illegal.
  - Otherwise -> EXEC.
  - imm_type is valid from DECODE onward.
- EXEC, per class:
  - R: alu_src_b=0, alu_op=10.
  - I-arith: alu_src_b=1, alu_op=10.
  - Load/store: alu_src_b=1, alu_op=00, then -> MEM.
  - LUI: alu_src_a=10, alu_src_b=1.
  - AUIPC: alu_src_a=01, alu_src_b=1.
  - R, I-arith, LUI, AUIPC -> WB.
  - Branch: alu_op=01; pc_write=1, pc_src = branch_taken ? 01 : 00; retire; -> FETCH.
  - JAL: alu_src_a=01, alu_src_b=1 -> WB.
  - JALR: alu_src_a=00, alu_src_b=1 -> WB.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=1 for store.
  - Hold until mem_ready.
  - Store: on ready, pc_write=1 with pc_src=00, retire, -> FETCH.
  - Load: on ready -> WB.
- WB:
  - reg_write=1 and pc_write=1, retire, -> FETCH.
  - wb_sel: 01 load, 10 JAL/JALR, 00 otherwise.
  - pc_src: 01 JAL, 10 JALR, 00 otherwise.
- TRAP: all enables 0; remains until reset.
- Retire means instret increments by 1 in the cycle that pc_write=1; it wraps modulo 2^CNT_W.
- Latency with zero-wait memory (mem_ready already high in the FETCH/MEM cycle):
  - Branch: 3 cycles.
  - R, I-arith, LUI, AUIPC, JAL, JALR, store: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait cycle adds exactly 1.
- x0 protection is the register file's job; reg_write asserts regardless of rd.

Decomposition:
- Shared package riscv_pkg holds:
  - The 10 opcode constants (7-bit binary literals).
  - The state enum: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
  - The imm_type, wb_sel, pc_src and alu_op encodings.
  - The same imm_type encoding is used by the immediate generator.
- One combinational sub-module, ctrl_decode: opcode -> one-hot class {R, I_ARITH, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, ILLEGAL}.
- FSM, counter and output logic stay in multicycle_ctrl.

Test Plan:
- Reset during FETCH wait, then release -> all outputs 0 while rst high; after release mem_req=1 and state=FETCH next cycle; no ir_write in the aborted access; instret=0.
- instr=0x00208033 (add), mem_ready always 1 -> states FETCH, DECODE, EXEC, WB, FETCH; reg_write=1 and wb_sel=00 in WB; instret=1 after 4 cycles.
- instr=0x0000A103 (lw), mem_ready low for 2 cycles in MEM -> mem_req/addr_sel=1 held for 3 cycles; then WB with wb_sel=01; total 7 cycles.
- instr=0x00208463 (beq):
  - branch_taken=1 -> pc_write with pc_src=01 in EXEC, back to FETCH after 3 cycles.
  - Repeat with branch_taken=0 -> pc_src=00.
- instr=0x000080E7 (jalr) -> WB with reg_write=1, wb_sel=10, pc_src=10, imm_type=0.
- instr=0x0000007F (illegal), then 0x00000073 (ecall) after reset:
  - illegal=1, state=TRAP, all enables 0 for 10 cycles.
  - halted=1 for ecall.
  - instret unchanged in both cases.
